// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver state encoding, frame width, default oversampling
// and the 2-of-3 vote used when USART_RX_MAJORITY_EN is defined.
package usart_pkg;

    localparam int USART_DATA_BITS  = 8;
    localparam int USART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } usart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops take RESET_VAL on reset so the output is at its idle level immediately.
module usart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usart_rx.sv
// Oversampled asynchronous receiver: 8N1 frames, LSB first, holding register with ready/read.
// Define USART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three samples.
module usart_rx
    import usart_pkg::*;
#(
    parameter int OVERSAMPLE = USART_OVERSAMPLE
) (
    input  logic         bit_clock_x16,
    input  logic         reset_n,
    input  logic         rx_pin,
    input  logic         read_in,
    output logic [7:0]   data_out,
    output logic         ready,
    output logic         framing_error,
    output logic         overrun,
    output logic         busy,
    output usart_state_e state_dbg
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(USART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(USART_DATA_BITS - 1);

    usart_state_e               state_q;
    logic [CW-1:0]              cnt_q;
    logic [BW-1:0]              bit_idx_q;
    logic [USART_DATA_BITS-1:0] shift_q;
    logic [USART_DATA_BITS-1:0] data_q;
    logic                       ready_q;
    logic                       fe_q;
    logic                       ovr_q;
    logic                       busy_q;
    logic                       rxs;
    logic                       bit_val;

    usart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i  (bit_clock_x16),
        .rst_ni (reset_n),
        .d_i    (rx_pin),
        .q_o    (rxs)
    );

`ifdef USART_RX_MAJORITY_EN
    // The two previous samples plus the current one cover counts H-2, H-1 and H.
    logic [1:0] hist_q;

    always_ff @(posedge bit_clock_x16 or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign bit_val = maj3(hist_q[1], hist_q[0], rxs);
`else
    assign bit_val = rxs;
`endif

    always_ff @(posedge bit_clock_x16 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // A read clears the flags; a load later in this block overrides it.
            if (read_in && ready_q) begin
                ready_q <= 1'b0;
                fe_q    <= 1'b0;
                ovr_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!bit_val) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        shift_q   <= {bit_val, shift_q[USART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        data_q  <= shift_q;
                        ready_q <= 1'b1;
                        fe_q    <= ~bit_val;
                        if (ready_q && !read_in) begin
                            ovr_q <= 1'b1;
                        end
                        // Leaving half a bit early lets a back-to-back start edge be seen.
                        if (bit_val) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_HIGH;
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = data_q;
    assign ready         = ready_q;
    assign framing_error = fe_q;
    assign overrun       = ovr_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_usart_rx.sv
// Randomized and directed bench for usart_rx: frames are driven on rx_pin cycle by cycle,
// expected presentations are queued by a line-level model and checked by a separate monitor.
module tb_usart_rx;
    import usart_pkg::*;

    localparam int OS       = 16;
    localparam int FRAME    = 10 * OS;
    localparam int LOAD_LAT = 155;   // 3 cycles to E, then H + 9*OS to the stop decision
    localparam int EW       = 42;    // {load cycle[31:0], overrun, framing_error, data[7:0]}

    logic         clk;
    logic         reset_n;
    logic         rx_pin;
    logic         read_in;
    logic [7:0]   data_out;
    logic         ready;
    logic         framing_error;
    logic         overrun;
    logic         busy;
    usart_state_e state_dbg;

    int cyc;
    int pass_cnt;
    int total_cnt;

    logic [EW-1:0] exp_q[$];

    // Model of the host-visible flags as seen from the line and the reads issued.
    logic       model_ready;
    logic       model_ovr;
    logic [7:0] model_last;

    logic       prev_ready;
    logic [9:0] prev_vec;

    usart_rx dut (
        .bit_clock_x16 (clk),
        .reset_n       (reset_n),
        .rx_pin        (rx_pin),
        .read_in       (read_in),
        .data_out      (data_out),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d items still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            pass_cnt++;
        end
    endtask

    // monitor / scoreboard: a presentation is ready rising or the held contents changing while ready
    always @(negedge clk) begin
        if (reset_n && ready &&
            (!prev_ready || {data_out, framing_error, overrun} != prev_vec)) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_byte: got data %02h fe %0b ovr %0b, expected no byte",
                         data_out, framing_error, overrun);
            end else begin
                chk("data_out", {24'd0, data_out}, {24'd0, exp_q[0][7:0]});
                chk("framing_error", {31'd0, framing_error}, {31'd0, exp_q[0][8]});
                chk("overrun", {31'd0, overrun}, {31'd0, exp_q[0][9]});
                chk("load_cycle", cyc, exp_q[0][41:10]);
                void'(exp_q.pop_front());
            end
        end
        prev_ready <= ready;
        prev_vec   <= {data_out, framing_error, overrun};
    end

    task automatic apply_reset_mid();
        reset_n = 1'b0;
        #1;
        chk("rst_data_out", {24'd0, data_out}, 32'h00);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_framing_error", {31'd0, framing_error}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n     = 1'b1;
        model_ready = 1'b0;
        model_ovr   = 1'b0;
    endtask

    // driver: one frame, k counts bit-clock cycles from the start-bit falling edge
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic coinc,
                              input int glitch_k, input int abort_k);
        logic [9:0] frame;
        logic       aborted;
        frame   = {stop, b, 1'b0};
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                aborted = 1'b1;
                break;
            end
            if (k == 0 && abort_k < 0) begin
                if (coinc) begin
                    model_ovr = 1'b0;
                end else if (model_ready) begin
                    model_ovr = 1'b1;
                end
                model_ready = 1'b1;
                model_last  = b;
                exp_q.push_back({32'(cyc + LOAD_LAT), model_ovr, ~stop, b});
            end
            rx_pin  = frame[k / OS] ^ (k == glitch_k);
            read_in = coinc && (k == LOAD_LAT - 1);
        end
        if (aborted) begin
            rx_pin  = 1'b1;
            read_in = 1'b0;
            apply_reset_mid();
        end
        read_in = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk);
        read_in = 1'b1;
        @(negedge clk);
        read_in     = 1'b0;
        model_ready = 1'b0;
        model_ovr   = 1'b0;
        chk("read_ready", {31'd0, ready}, 32'd0);
        chk("read_framing_error", {31'd0, framing_error}, 32'd0);
        chk("read_overrun", {31'd0, overrun}, 32'd0);
    endtask

    task automatic idle(input int n);
        rx_pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         f;
        logic [7:0] b;
        logic       stop;
        pass_cnt    = 0;
        total_cnt   = 0;
        model_ready = 1'b0;
        model_ovr   = 1'b0;
        model_last  = 8'h00;
        reset_n     = 1'b0;
        rx_pin      = 1'b1;
        read_in     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, data_out}, 32'h00);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_framing_error", {31'd0, framing_error}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_state", {29'd0, state_dbg}, {29'd0, IDLE});
        reset_n = 1'b1;
        idle(5);

        // good frame
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        idle(10);
        do_read();

        // 5-cycle low pulse must be rejected at the start check
        @(negedge clk);
        f      = cyc;
        rx_pin = 1'b0;
        repeat (5) @(negedge clk);
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_timing", cyc, f + 11);
        idle(20);

        // break: stop bit low, line held low two more bit times
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
        repeat (2 * OS) @(negedge clk);
        idle(6);
        chk("break_busy_low", {31'd0, busy}, 32'd0);
        do_read();
        idle(8);

        // back-to-back, no read: overrun
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1, -1);
        idle(8);
        chk("b2b_data", {24'd0, data_out}, {24'd0, model_last});
        chk("b2b_overrun", {31'd0, overrun}, {31'd0, model_ovr});
        chk("b2b_ready", {31'd0, ready}, {31'd0, model_ready});
        do_read();
        idle(8);

        // read coincident with the second load
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, 1'b1, -1, -1);
        idle(8);
        chk("coinc_ready", {31'd0, ready}, 32'd1);
        chk("coinc_overrun", {31'd0, overrun}, 32'd0);
        do_read();
        idle(8);

        // reset during data bit 4, with an unread byte held
        send_frame(8'h77, 1'b1, 1'b0, -1, -1);
        idle(8);
        send_frame(8'hC3, 1'b1, 1'b0, -1, 5 * OS + 4);
        idle(8);
        send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
        idle(8);
        do_read();
        idle(8);

`ifdef USART_RX_MAJORITY_EN
        // single inverted sample at the data-bit-0 decision point is outvoted
        send_frame(8'h01, 1'b1, 1'b0, OS + OS / 2, -1);
        idle(8);
        do_read();
        idle(8);
`endif

        // randomized traffic
        for (int n = 0; n < 14; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            if (model_ready && b == model_last) begin
                b = b ^ 8'h01;
            end
            send_frame(b, stop, 1'b0, -1, -1);
            if (!stop) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            idle($urandom_range(4, 30));
            if ($urandom_range(0, 1) == 1) begin
                do_read();
            end
        end

        idle(200);
        chk("expected_queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
